// File: rtl/leiwand_rv32_wb_uart_tx_pkg.sv
// Purpose: shared definitions for the Wishbone UART transmitter (register map, STATUS bits, FSM states).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package leiwand_rv32_wb_uart_tx_pkg;

    // Register offsets, decoded from wb_addr[3:2]
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_RSVD   = 2'd3;

    // STATUS bit indices
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam int BAUD_W = 16;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Dividers below 2 would make a zero-length bit; clamp them to 2.
    function automatic logic [BAUD_W-1:0] eff_div(input logic [BAUD_W-1:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/leiwand_rv32_sync_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO; pointers carry an extra wrap bit.
// Latency: push visible on pop_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk/rst (async active-high), push/push_dat, pop/pop_dat, full, empty, count.
module leiwand_rv32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Same index, different lap => full.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/leiwand_rv32_wb_uart_tx.sv
// Purpose: Wishbone responder with an 8N1 LSB-first UART transmitter fed by a TX FIFO.
// Latency: every accepted access acked exactly one cycle later; line falls one cycle after the push.
// Backpressure: none on the bus (wb_stall=0); pushes into a full FIFO are dropped and flag ovf.
// Ports: CLK/RST (async active-high); wb_* Wishbone responder; data_write_size in bytes;
//        uart_tx serial line (idle high); tx_empty_irq = FIFO empty and shifter idle.
module leiwand_rv32_wb_uart_tx
    import leiwand_rv32_wb_uart_tx_pkg::*;
#(
    parameter int MEM_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 104
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [MEM_WIDTH-1:0] wb_addr,
    input  logic [MEM_WIDTH-1:0] wb_data_in,
    output logic [MEM_WIDTH-1:0] wb_data_out,
    input  logic                 wb_we,
    input  logic                 wb_stb,
    output logic                 wb_ack,
    input  logic                 wb_cyc,
    output logic                 wb_stall,
    input  logic [2:0]           data_write_size,
    output logic                 uart_tx,
    output logic                 tx_empty_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     CNT_ZERO = '0;
    localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [BAUD_W-1:0] BAUD_RST = CLK_DIV[BAUD_W-1:0];

    // ---------------- bus side ----------------
    logic                 acc;
    logic [1:0]           reg_sel;
    logic                 wr_tx;
    logic                 wr_stat;
    logic                 wr_baud;
    logic [MEM_WIDTH-1:0] rd_val;
    logic [BAUD_W-1:0]    baud_div;
    logic                 ovf;

    // ---------------- FIFO ----------------
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    // ---------------- transmitter ----------------
    tx_state_t            state, state_nxt;
    logic [BAUD_W-1:0]    cnt, cnt_nxt;
    logic [2:0]           bit_idx, bit_nxt;
    logic [7:0]           shift, shift_nxt;
    logic                 tx_q, tx_nxt;
    logic                 irq_q, irq_nxt;
    logic                 busy;
    logic [BAUD_W-1:0]    reload;
    logic                 empty_nxt;

    logic unused_bits;
    assign unused_bits = ^{wb_addr[MEM_WIDTH-1:4], wb_addr[1:0], wb_data_in[MEM_WIDTH-1:BAUD_W]};

    assign acc     = wb_cyc && wb_stb;
    assign reg_sel = wb_addr[3:2];
    assign wr_tx   = acc && wb_we && (reg_sel == UART_TXDATA);
    assign wr_stat = acc && wb_we && (reg_sel == UART_STATUS);
    assign wr_baud = acc && wb_we && (reg_sel == UART_BAUD);

    // Full is the pre-edge value, so a pop in the same cycle cannot make room for this push.
    assign fifo_push = wr_tx && !fifo_full;
    assign busy      = (state != TX_IDLE);

    always_comb begin
        rd_val = '0;
        case (reg_sel)
            UART_STATUS: begin
                rd_val[STAT_FULL]  = fifo_full;
                rd_val[STAT_EMPTY] = fifo_empty;
                rd_val[STAT_BUSY]  = busy;
                rd_val[STAT_OVF]   = ovf;
            end
            UART_BAUD:   rd_val[BAUD_W-1:0] = baud_div;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_ack      <= 1'b0;
            wb_data_out <= '0;
            baud_div    <= BAUD_RST;
            ovf         <= 1'b0;
        end else begin
            wb_ack      <= acc;
            wb_data_out <= (acc && !wb_we) ? rd_val : '0;
            if (wr_baud) begin
                if (data_write_size == 3'd1) baud_div[7:0] <= wb_data_in[7:0];
                else                         baud_div      <= wb_data_in[BAUD_W-1:0];
            end
            if (wr_tx && fifo_full)                  ovf <= 1'b1;
            else if (wr_stat && wb_data_in[STAT_OVF]) ovf <= 1'b0;
        end
    end

    assign wb_stall = 1'b0;

    leiwand_rv32_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (fifo_push),
        .push_dat (wb_data_in[7:0]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Reload is taken from the live divider at each bit edge, so a new value
    // applies from the next bit onward.
    assign reload = eff_div(baud_div) - 16'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx_q;
        fifo_pop  = 1'b0;
        case (state)
            TX_IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_dout;
                    state_nxt = TX_START;
                    cnt_nxt   = reload;
                    tx_nxt    = 1'b0;
                end
            end
            TX_START: begin
                if (cnt == '0) begin
                    state_nxt = TX_DATA;
                    cnt_nxt   = reload;
                    bit_nxt   = 3'd0;
                    tx_nxt    = shift[0];
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (cnt == '0) begin
                    cnt_nxt = reload;
                    if (bit_idx == 3'd7) begin
                        state_nxt = TX_STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt   = bit_idx + 3'd1;
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (cnt == '0) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_nxt = fifo_dout;
                        state_nxt = TX_START;
                        cnt_nxt   = reload;
                        tx_nxt    = 1'b0;
                    end else begin
                        state_nxt = TX_IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // The irq register tracks next-cycle emptiness so it drops on the very
    // edge that pushes a byte and rises on the edge that returns to idle.
    assign empty_nxt = ((fifo_count == CNT_ZERO) && !fifo_push) ||
                       ((fifo_count == CNT_ONE) && fifo_pop && !fifo_push);
    assign irq_nxt   = empty_nxt && (state_nxt == TX_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            tx_q    <= tx_nxt;
            irq_q   <= irq_nxt;
        end
    end

    assign uart_tx      = tx_q;
    assign tx_empty_irq = irq_q;

endmodule
